// File: rtl/replay_pkg.sv
// Shared constants and state encoding for the sample replay controller and its memory.
package replay_pkg;

  localparam int ADDR_WIDTH = 17;
  localparam int DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECORD = 2'd1,
    ST_PLAY   = 2'd2
  } state_t;

endpackage

// File: rtl/replay_controller.sv
// Record/playback sequencer driving an external dual-port sample memory:
// port A records live samples, port B plays them back with a 2-cycle output latency.
module replay_controller #(
  parameter int ADDR_WIDTH = replay_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = replay_pkg::DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sample_valid,
  input  logic signed [DATA_WIDTH-1:0] sample_in,
  input  logic                         rec_start,
  input  logic                         rec_stop,
  input  logic                         play_start,
  input  logic                         play_stop,
  input  logic                         loop_en,
  output logic        [ADDR_WIDTH-1:0] addr_a,
  output logic        [DATA_WIDTH-1:0] data_in_a,
  output logic                         write_enable_a,
  output logic                         read_enable_a,
  output logic        [ADDR_WIDTH-1:0] addr_b,
  output logic                         read_enable_b,
  input  logic signed [DATA_WIDTH-1:0] data_out_b,
  output logic signed [DATA_WIDTH-1:0] sample_out,
  output logic                         sample_out_valid,
  output logic        [1:0]            state,
  output logic        [ADDR_WIDTH:0]   rec_len,
  output logic                         full
);

  import replay_pkg::*;

  localparam logic [ADDR_WIDTH:0]   CAPACITY  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                         r_state;
  state_t                         w_next;

  logic        [ADDR_WIDTH-1:0]   r_wr_ptr;
  logic        [ADDR_WIDTH-1:0]   r_rd_ptr;
  logic        [ADDR_WIDTH:0]     r_rec_len;
  logic                           r_full;
  logic signed [DATA_WIDTH-1:0]   r_sample_out;
  logic                           r_out_valid;
  logic                           r_pend;
  logic                           r_pend_last;
  logic                           r_out_last;
  logic                           r_drain;

  logic                           w_we;
  logic                           w_re;
  logic                           w_wr_last;
  logic                           w_rd_last;
  logic        [ADDR_WIDTH:0]     w_wr_cnt;
  logic                           w_enter_idle;

  assign w_wr_last    = (r_wr_ptr == LAST_ADDR);
  assign w_rd_last    = ({1'b0, r_rd_ptr} == (r_rec_len - (ADDR_WIDTH+1)'(1)));
  assign w_wr_cnt     = {1'b0, r_wr_ptr} + {{ADDR_WIDTH{1'b0}}, w_we};
  assign w_enter_idle = (r_state != ST_IDLE) && (w_next == ST_IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (rec_start)                         w_next = ST_RECORD;
        else if (play_start && r_rec_len != '0) w_next = ST_PLAY;
      end
      ST_RECORD: begin
        if (rec_stop || (w_we && w_wr_last))   w_next = ST_IDLE;
      end
      ST_PLAY: begin
        if (play_stop || r_out_last)           w_next = ST_IDLE;
      end
      default:                                 w_next = ST_IDLE;
    endcase
  end

  // Memory-port outputs; once a non-looping playback has issued its final read,
  // further strobes are not turned into reads while the last sample drains.
  always_comb begin
    w_we      = 1'b0;
    w_re      = 1'b0;
    addr_a    = '0;
    data_in_a = '0;
    addr_b    = '0;
    case (r_state)
      ST_RECORD: begin
        w_we      = sample_valid;
        addr_a    = r_wr_ptr;
        data_in_a = sample_in;
      end
      ST_PLAY: begin
        w_re   = sample_valid && !r_drain;
        addr_b = r_rd_ptr;
      end
      default: ;
    endcase
  end

  // Datapath: pointers, recording length and the two-stage playback pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_rec_len    <= '0;
      r_full       <= 1'b0;
      r_sample_out <= '0;
      r_out_valid  <= 1'b0;
      r_pend       <= 1'b0;
      r_pend_last  <= 1'b0;
      r_out_last   <= 1'b0;
      r_drain      <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && w_next == ST_RECORD) begin
        r_wr_ptr  <= '0;
        r_rec_len <= '0;
        r_full    <= 1'b0;
      end
      if (r_state == ST_IDLE && w_next == ST_PLAY) begin
        r_rd_ptr <= '0;
        r_drain  <= 1'b0;
      end

      if (w_we) begin
        if (w_wr_last) begin
          r_rec_len <= CAPACITY;
          r_full    <= 1'b1;
        end else begin
          r_wr_ptr  <= r_wr_ptr + 1'b1;
        end
      end
      if (r_state == ST_RECORD && rec_stop) r_rec_len <= w_wr_cnt;

      if (w_re) begin
        if (!w_rd_last)   r_rd_ptr <= r_rd_ptr + 1'b1;
        else if (loop_en) r_rd_ptr <= '0;
        else              r_drain  <= 1'b1;
      end
      r_pend      <= w_re;
      r_pend_last <= w_re && w_rd_last && !loop_en;

      r_out_valid <= r_pend;
      r_out_last  <= r_pend && r_pend_last;
      if (r_pend) r_sample_out <= data_out_b;

      // Leaving RECORD/PLAY silences the output and drops any read still in flight
      if (w_enter_idle) begin
        r_sample_out <= '0;
        r_out_valid  <= 1'b0;
        r_pend       <= 1'b0;
        r_pend_last  <= 1'b0;
        r_out_last   <= 1'b0;
        r_drain      <= 1'b0;
      end
    end
  end

  assign write_enable_a   = w_we;
  assign read_enable_a    = 1'b0;
  assign read_enable_b    = w_re;
  assign sample_out       = r_sample_out;
  assign sample_out_valid = r_out_valid;
  assign state            = r_state;
  assign rec_len          = r_rec_len;
  assign full             = r_full;

endmodule

// File: tb/tb_replay_controller.sv
// Directed bench for replay_controller with a 16-entry behavioural dual-port memory.
module tb_replay_controller;

  localparam int AW = 4;
  localparam int DW = 16;

  localparam logic [5:0] C_RS = 6'b100000;
  localparam logic [5:0] C_RP = 6'b010000;
  localparam logic [5:0] C_PS = 6'b001000;
  localparam logic [5:0] C_PP = 6'b000100;
  localparam logic [5:0] C_LP = 6'b000010;
  localparam logic [5:0] C_SV = 6'b000001;

  typedef struct packed {
    logic [5:0]  cmd;
    logic [15:0] sin;
  } vin_t;

  typedef struct packed {
    logic [1:0]  st;
    logic        we;
    logic [3:0]  aa;
    logic [15:0] da;
    logic        rb;
    logic [3:0]  ab;
    logic [15:0] so;
    logic        sov;
    logic [4:0]  len;
    logic        full;
  } vout_t;

  typedef struct packed {
    vin_t  i;
    vout_t o;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 sample_valid = 1'b0;
  logic signed [DW-1:0] sample_in = '0;
  logic                 rec_start = 1'b0, rec_stop = 1'b0;
  logic                 play_start = 1'b0, play_stop = 1'b0;
  logic                 loop_en = 1'b0;
  logic [AW-1:0]        addr_a, addr_b;
  logic [DW-1:0]        data_in_a;
  logic                 write_enable_a, read_enable_a, read_enable_b;
  logic signed [DW-1:0] data_out_b;
  logic signed [DW-1:0] sample_out;
  logic                 sample_out_valid;
  logic [1:0]           state;
  logic [AW:0]          rec_len;
  logic                 full;

  logic [DW-1:0] mem [2**AW];
  vec_t          tbl [$];
  int            n_chk  = 0;
  int            n_pass = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (write_enable_a) mem[addr_a] <= data_in_a;
    if (read_enable_b)  data_out_b  <= mem[addr_b];
  end

  replay_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_in(sample_in),
    .rec_start(rec_start), .rec_stop(rec_stop), .play_start(play_start),
    .play_stop(play_stop), .loop_en(loop_en),
    .addr_a(addr_a), .data_in_a(data_in_a), .write_enable_a(write_enable_a),
    .read_enable_a(read_enable_a), .addr_b(addr_b), .read_enable_b(read_enable_b),
    .data_out_b(data_out_b), .sample_out(sample_out),
    .sample_out_valid(sample_out_valid), .state(state), .rec_len(rec_len), .full(full)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic add(input logic [5:0] cmd, input int sin, input int st, input int we,
                     input int aa, input int da, input int rb, input int ab,
                     input int so, input int sov, input int len, input int f);
    vec_t v;
    v.i.cmd  = cmd;     v.i.sin = 16'(sin);
    v.o.st   = 2'(st);  v.o.we  = 1'(we);  v.o.aa  = 4'(aa);  v.o.da   = 16'(da);
    v.o.rb   = 1'(rb);  v.o.ab  = 4'(ab);  v.o.so  = 16'(so); v.o.sov  = 1'(sov);
    v.o.len  = 5'(len); v.o.full = 1'(f);
    tbl.push_back(v);
  endtask

  task automatic step(input logic [5:0] cmd, input int sin);
    @(posedge clk);
    #1;
    {rec_start, rec_stop, play_start, play_stop, loop_en, sample_valid} = cmd;
    sample_in = 16'(sin);
    @(negedge clk);
  endtask

  function automatic vout_t actual();
    vout_t a;
    a.st = state;          a.we = write_enable_a; a.aa = addr_a; a.da = data_in_a;
    a.rb = read_enable_b;  a.ab = addr_b;         a.so = sample_out;
    a.sov = sample_out_valid; a.len = rec_len;    a.full = full;
    return a;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // cmd, sin | st we aa da rb ab so sov len full
    add(0,            0,   0,0,0,0,   0,0,0,0,   0,0);
    add(C_RS,         0,   0,0,0,0,   0,0,0,0,   0,0);
    add(C_SV,         100, 1,1,0,100, 0,0,0,0,   0,0);
    add(C_SV,         101, 1,1,1,101, 0,0,0,0,   0,0);
    add(0,            0,   1,0,2,0,   0,0,0,0,   0,0);
    add(C_SV,         102, 1,1,2,102, 0,0,0,0,   0,0);
    add(C_SV,         103, 1,1,3,103, 0,0,0,0,   0,0);
    add(C_SV|C_RP,    104, 1,1,4,104, 0,0,0,0,   0,0);
    add(C_PS,         0,   0,0,0,0,   0,0,0,0,   5,0);
    add(C_SV,         0,   2,0,0,0,   1,0,0,0,   5,0);
    add(0,            0,   2,0,0,0,   0,1,0,0,   5,0);
    add(C_SV,         0,   2,0,0,0,   1,1,100,1, 5,0);
    add(C_SV,         0,   2,0,0,0,   1,2,100,0, 5,0);
    add(C_SV,         0,   2,0,0,0,   1,3,101,1, 5,0);
    add(C_SV,         0,   2,0,0,0,   1,4,102,1, 5,0);
    add(0,            0,   2,0,0,0,   0,4,103,1, 5,0);
    add(0,            0,   2,0,0,0,   0,4,104,1, 5,0);
    add(0,            0,   0,0,0,0,   0,0,0,0,   5,0);
    add(C_PS|C_LP,    0,   0,0,0,0,   0,0,0,0,   5,0);
    add(C_SV|C_LP,    0,   2,0,0,0,   1,0,0,0,   5,0);
    add(C_SV|C_LP,    0,   2,0,0,0,   1,1,0,0,   5,0);
    add(C_SV|C_LP,    0,   2,0,0,0,   1,2,100,1, 5,0);
    add(C_SV|C_LP,    0,   2,0,0,0,   1,3,101,1, 5,0);
    add(C_SV|C_LP,    0,   2,0,0,0,   1,4,102,1, 5,0);
    add(C_SV|C_LP,    0,   2,0,0,0,   1,0,103,1, 5,0);
    add(C_SV|C_LP,    0,   2,0,0,0,   1,1,104,1, 5,0);
    add(C_LP,         0,   2,0,0,0,   0,2,100,1, 5,0);
    add(C_LP,         0,   2,0,0,0,   0,2,101,1, 5,0);
    add(C_PP|C_LP,    0,   2,0,0,0,   0,2,101,0, 5,0);
    add(C_LP,         0,   0,0,0,0,   0,0,0,0,   5,0);
    add(C_PS|C_LP,    0,   0,0,0,0,   0,0,0,0,   5,0);
    add(C_SV|C_LP,    0,   2,0,0,0,   1,0,0,0,   5,0);
    add(C_PP|C_LP,    0,   2,0,0,0,   0,1,0,0,   5,0);
    add(0,            0,   0,0,0,0,   0,0,0,0,   5,0);
    add(0,            0,   0,0,0,0,   0,0,0,0,   5,0);
    add(C_RP|C_PP,    0,   0,0,0,0,   0,0,0,0,   5,0);
    add(0,            0,   0,0,0,0,   0,0,0,0,   5,0);
    add(C_RS|C_PS,    0,   0,0,0,0,   0,0,0,0,   5,0);
    add(C_RS|C_PS,    0,   1,0,0,0,   0,0,0,0,   0,0);
    add(C_RP,         0,   1,0,0,0,   0,0,0,0,   0,0);
    add(C_PS,         0,   0,0,0,0,   0,0,0,0,   0,0);
    add(0,            0,   0,0,0,0,   0,0,0,0,   0,0);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    foreach (tbl[k]) begin
      step(tbl[k].i.cmd, int'(tbl[k].i.sin));
      chk($sformatf("row%0d", k), 64'(actual()), 64'(tbl[k].o));
    end

    // Fill all 16 locations; capacity stops recording without wrapping
    step(C_RS, 0);
    for (int unsigned i = 0; i < 16; i++) begin
      step(C_SV, 1000 + int'(i));
      chk($sformatf("fill_wr%0d", i), {59'd0, write_enable_a, addr_a}, {59'd0, 1'b1, 4'(i)});
    end
    step(C_SV, 2000);
    chk("full_stop", {54'd0, state, full, rec_len, write_enable_a},
        {54'd0, 2'd0, 1'b1, 5'd16, 1'b0});

    // Play back from address 0 (must still hold 1000), then reset mid-flight
    step(C_PS, 0);
    step(C_SV, 0);
    chk("full_play_st", 64'(state), 64'd2);
    step(0, 0);
    step(C_SV, 0);
    chk("full_play_out", {47'd0, sample_out, sample_out_valid}, {47'd0, 16'd1000, 1'b1});
    @(posedge clk);
    #1;
    {rec_start, rec_stop, play_start, play_stop, loop_en, sample_valid} = '0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_play", {36'd0, state, sample_out, sample_out_valid, rec_len, full,
                         write_enable_a, read_enable_b, read_enable_a},
        64'd0);
    for (int unsigned i = 0; i < 3; i++) begin
      step(0, 0);
      chk($sformatf("rst_no_pulse%0d", i), 64'(sample_out_valid), 64'd0);
    end
    step(C_PS, 0);
    step(0, 0);
    chk("play_after_rst", 64'(state), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
